trace_retire_sequencer: RTL and testbench

- Collects retired instructions from the core's two retirement lanes and merges them into one in-order trace stream with a valid/ready handshake.
- Sits between the core retire interface and the testbench tracer/logger.
- Classifies each instruction with the team's tracer instruction masks (32-bit and compressed).
- Buffers retirements in a 2-write/1-read FIFO; drops and counts retirements it has no room for.

---
 rtl/trace_retire_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_trace_retire_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_retire_sequencer.sv
// Merges two in-order retirement lanes into one classified trace stream via a 2-write/1-read FIFO.
// Optional macro TRACE_BACKPRESSURE_EN adds a registered retire_stall and a stall-cycle counter.
module trace_retire_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             r0_valid,
    input  logic [31:0]      r0_pc,
    input  logic [31:0]      r0_insn,
    input  logic             r1_valid,
    input  logic [31:0]      r1_pc,
    input  logic [31:0]      r1_insn,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_insn,
    output logic [2:0]       trace_class,
    output logic             trace_compressed,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow,
    output logic             retire_stall
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] C_DEPTH    = OW'(DEPTH);
    localparam logic [OW-1:0] C_DEPTH_M2 = OW'(DEPTH - 2);

    localparam logic [2:0] CLS_OTHER  = 3'd0;
    localparam logic [2:0] CLS_BRANCH = 3'd1;
    localparam logic [2:0] CLS_JUMP   = 3'd2;
    localparam logic [2:0] CLS_LOAD   = 3'd3;
    localparam logic [2:0] CLS_STORE  = 3'd4;
    localparam logic [2:0] CLS_CSR    = 3'd5;
    localparam logic [2:0] CLS_SYSTEM = 3'd6;
    localparam logic [2:0] CLS_FENCE  = 3'd7;

    function automatic logic [2:0] classify(input logic [31:0] insn);
        logic [2:0] cls;
        logic [2:0] f3;
        logic [2:0] cf3;
        logic [4:0] crs1;
        logic [4:0] crs2;
        cls  = CLS_OTHER;
        f3   = insn[14:12];
        cf3  = insn[15:13];
        crs1 = insn[11:7];
        crs2 = insn[6:2];
        if (insn[1:0] == 2'b11) begin
            case (insn[6:0])
                7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) cls = CLS_BRANCH;
                7'b1101111: cls = CLS_JUMP;
                7'b1100111: if (f3 == 3'b000) cls = CLS_JUMP;
                7'b0000011: cls = CLS_LOAD;
                7'b0100011: cls = CLS_STORE;
                7'b0001111: if (f3 == 3'b000 || f3 == 3'b001) cls = CLS_FENCE;
                7'b1110011: begin
                    // funct3==0 holds ECALL/EBREAK/xRET/WFI, identified by the immediate
                    if (f3 == 3'b000) begin
                        if (insn[19:7] == 13'd0 &&
                            (insn[31:20] == 12'h000 || insn[31:20] == 12'h001 ||
                             insn[31:20] == 12'h302 || insn[31:20] == 12'h7B2 ||
                             insn[31:20] == 12'h105))
                            cls = CLS_SYSTEM;
                    end else if (f3 != 3'b100) begin
                        cls = CLS_CSR;
                    end
                end
                default: cls = CLS_OTHER;
            endcase
        end else begin
            case (insn[1:0])
                2'b00: begin
                    if (cf3 == 3'b010) cls = CLS_LOAD;
                    else if (cf3 == 3'b110) cls = CLS_STORE;
                end
                2'b01: begin
                    if (cf3 == 3'b001 || cf3 == 3'b101) cls = CLS_JUMP;
                    else if (cf3 == 3'b110 || cf3 == 3'b111) cls = CLS_BRANCH;
                end
                default: begin
                    if (cf3 == 3'b010) begin
                        cls = CLS_LOAD;
                    end else if (cf3 == 3'b110) begin
                        cls = CLS_STORE;
                    end else if (cf3 == 3'b100) begin
                        // rs2==0 selects JR/JALR/EBREAK over MV/ADD; rs1==0 with bit12 is EBREAK
                        if (!insn[12]) begin
                            if (crs2 == 5'd0 && crs1 != 5'd0) cls = CLS_JUMP;
                        end else if (crs2 == 5'd0) begin
                            cls = (crs1 == 5'd0) ? CLS_SYSTEM : CLS_JUMP;
                        end
                    end
                end
            endcase
        end
        return cls;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [31:0]      r_pc_mem   [DEPTH];
    logic [31:0]      r_insn_mem [DEPTH];
    logic [2:0]       r_cls_mem  [DEPTH];
    logic             r_comp_mem [DEPTH];

    logic [OW-1:0]    r_occ;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_overflow;

    logic             w_has1;
    logic             w_has2;
    logic             w_wr0;
    logic             w_wr1;
    logic             w_drop0;
    logic             w_drop1;
    logic [1:0]       w_n_wr;
    logic [1:0]       w_n_drop;
    logic             w_pop;
    logic [AW-1:0]    w_slot1;
    logic [OW-1:0]    w_occ_nxt;
    logic [2:0]       w_cls0;
    logic [2:0]       w_cls1;

    // Space is judged on the registered occupancy only; a same-cycle pop gives no credit
    assign w_has1    = (r_occ < C_DEPTH);
    assign w_has2    = (r_occ <= C_DEPTH_M2);
    assign w_wr0     = !flush && r0_valid && w_has1;
    assign w_wr1     = !flush && r1_valid && (r0_valid ? w_has2 : w_has1);
    assign w_drop0   = !flush && r0_valid && !w_wr0;
    assign w_drop1   = !flush && r1_valid && !w_wr1;
    assign w_n_wr    = {1'b0, w_wr0} + {1'b0, w_wr1};
    assign w_n_drop  = {1'b0, w_drop0} + {1'b0, w_drop1};
    assign w_pop     = trace_valid && trace_ready && !flush;
    assign w_slot1   = w_wr0 ? (r_wptr + AW'(1)) : r_wptr;
    assign w_occ_nxt = flush ? '0 : (r_occ + OW'(w_n_wr) - OW'(w_pop));
    assign w_cls0    = classify(r0_insn);
    assign w_cls1    = classify(r1_insn);

    always_ff @(posedge clk) begin
        if (w_wr0) begin
            r_pc_mem[r_wptr]   <= r0_pc;
            r_insn_mem[r_wptr] <= r0_insn;
            r_cls_mem[r_wptr]  <= w_cls0;
            r_comp_mem[r_wptr] <= (r0_insn[1:0] != 2'b11);
        end
        if (w_wr1) begin
            r_pc_mem[w_slot1]   <= r1_pc;
            r_insn_mem[w_slot1] <= r1_insn;
            r_cls_mem[w_slot1]  <= w_cls1;
            r_comp_mem[w_slot1] <= (r1_insn[1:0] != 2'b11);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_occ <= w_occ_nxt;
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                r_wptr <= r_wptr + AW'(w_n_wr);
                if (w_pop) r_rptr <= r_rptr + AW'(1);
            end
            r_drop_cnt <= sat_add(r_drop_cnt, w_n_drop);
            if (w_n_drop != 2'd0) r_overflow <= 1'b1;
        end
    end

`ifdef TRACE_BACKPRESSURE_EN
    logic             r_retire_stall;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_stall <= 1'b0;
            r_stall_cnt    <= '0;
        end else begin
            r_retire_stall <= (w_occ_nxt > C_DEPTH_M2);
            if (trace_valid && !trace_ready) r_stall_cnt <= sat_add(r_stall_cnt, 2'd1);
        end
    end

    assign retire_stall = r_retire_stall;
`else
    assign retire_stall = 1'b0;
`endif

    // Head fields are gated by valid so an empty or reset FIFO presents zeros
    assign trace_valid      = (r_occ != '0);
    assign trace_pc         = trace_valid ? r_pc_mem[r_rptr]   : 32'd0;
    assign trace_insn       = trace_valid ? r_insn_mem[r_rptr] : 32'd0;
    assign trace_class      = trace_valid ? r_cls_mem[r_rptr]  : 3'd0;
    assign trace_compressed = trace_valid ? r_comp_mem[r_rptr] : 1'b0;
    assign drop_count       = r_drop_cnt;
    assign overflow         = r_overflow;

endmodule

// File: tb/tb_trace_retire_sequencer.sv
// Self-checking bench for trace_retire_sequencer: vector table plus corner-case sequences against a queue model.
module tb_trace_retire_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        r0_valid = 1'b0;
    logic [31:0] r0_pc = 32'd0;
    logic [31:0] r0_insn = 32'd0;
    logic        r1_valid = 1'b0;
    logic [31:0] r1_pc = 32'd0;
    logic [31:0] r1_insn = 32'd0;
    logic        trace_ready = 1'b0;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_insn;
    logic [2:0]  trace_class;
    logic        trace_compressed;
    logic [15:0] drop_count;
    logic        overflow;
    logic        retire_stall;

    trace_retire_sequencer #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .r0_valid(r0_valid), .r0_pc(r0_pc), .r0_insn(r0_insn),
        .r1_valid(r1_valid), .r1_pc(r1_pc), .r1_insn(r1_insn),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_insn(trace_insn), .trace_class(trace_class),
        .trace_compressed(trace_compressed), .drop_count(drop_count),
        .overflow(overflow), .retire_stall(retire_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [2:0]  cls;
    } ent_t;

    typedef struct {
        bit          v0;
        logic [31:0] pc0;
        logic [31:0] i0;
        logic [2:0]  c0;
        bit          v1;
        logic [31:0] pc1;
        logic [31:0] i1;
        logic [2:0]  c1;
        bit          rdy;
    } vec_t;

    ent_t exp_q[$];
    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_drop = 0;
    bit   m_ovf = 1'b0;
    bit   m_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] hi;
        chk("trace_valid", 32'(trace_valid), 32'(exp_q.size() != 0));
        chk("occ", 32'(dut.r_occ), 32'(exp_q.size()));
        if (exp_q.size() != 0) begin
            hi = exp_q[0].insn;
            chk("head_pc", trace_pc, exp_q[0].pc);
            chk("head_insn", trace_insn, hi);
            chk("head_class", 32'(trace_class), 32'(exp_q[0].cls));
            chk("head_compressed", 32'(trace_compressed), 32'(hi[1:0] != 2'b11));
        end
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("retire_stall", 32'(retire_stall), 32'(m_stall));
    endtask

    // Checks the current outputs, drives one cycle of stimulus, updates the model and advances to the next negedge
    task automatic step(input bit v0, input logic [31:0] pc0, input logic [31:0] i0, input logic [2:0] c0,
                        input bit v1, input logic [31:0] pc1, input logic [31:0] i1, input logic [2:0] c1,
                        input bit rdy, input bit fl);
        int occ;
        int free;
        bit w0;
        bit w1;
        int nd;
        check_outputs();
        r0_valid = v0; r0_pc = pc0; r0_insn = i0;
        r1_valid = v1; r1_pc = pc1; r1_insn = i1;
        trace_ready = rdy; flush = fl;
        occ = exp_q.size();
        free = 8 - occ;
        if (fl) begin
            exp_q.delete();
        end else begin
            w0 = v0 && (free >= 1);
            w1 = v1 && (v0 ? (free >= 2) : (free >= 1));
            nd = int'(v0 && !w0) + int'(v1 && !w1);
            if (occ != 0 && rdy) void'(exp_q.pop_front());
            if (w0) exp_q.push_back('{pc0, i0, c0});
            if (w1) exp_q.push_back('{pc1, i1, c1});
            m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
            if (nd != 0) m_ovf = 1'b1;
        end
`ifdef TRACE_BACKPRESSURE_EN
        m_stall = (exp_q.size() > 6);
`else
        m_stall = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(0, 32'd0, 32'd0, 3'd0, 0, 32'd0, 32'd0, 3'd0, rdy, 0);
    endtask

    task automatic dual(input logic [31:0] pc, input bit rdy);
        step(1, pc, 32'h00A00093, 3'd0, 1, pc + 32'd4, 32'h0000006F, 3'd2, rdy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{1, 32'h100, 32'h00A00093, 3'd0, 1, 32'h104, 32'h0000006F, 3'd2, 1});
        vecs.push_back('{0, 32'h0,   32'h0,        3'd0, 0, 32'h0,   32'h0,        3'd0, 1});
        vecs.push_back('{0, 32'h0,   32'h0,        3'd0, 0, 32'h0,   32'h0,        3'd0, 1});
        vecs.push_back('{1, 32'h200, 32'h00009002, 3'd6, 0, 32'h0,   32'h0,        3'd0, 1});
        vecs.push_back('{0, 32'h0,   32'h0,        3'd0, 1, 32'h202, 32'h00008082, 3'd2, 1});
        vecs.push_back('{1, 32'h204, 32'h00004108, 3'd3, 1, 32'h206, 32'h00002003, 3'd3, 1});
        vecs.push_back('{1, 32'h20A, 32'h00000063, 3'd1, 1, 32'h20E, 32'h00002023, 3'd4, 1});
        vecs.push_back('{1, 32'h212, 32'h34011073, 3'd5, 1, 32'h216, 32'h00000073, 3'd6, 1});
        vecs.push_back('{1, 32'h21A, 32'h30200073, 3'd6, 1, 32'h21E, 32'h0000000F, 3'd7, 1});
        vecs.push_back('{0, 32'h0,   32'h0,        3'd0, 0, 32'h0,   32'h0,        3'd0, 1});
        vecs.push_back('{0, 32'h0,   32'h0,        3'd0, 0, 32'h0,   32'h0,        3'd0, 1});
        vecs.push_back('{1, 32'h222, 32'h0000A001, 3'd2, 1, 32'h224, 32'h0000C001, 3'd1, 1});
        vecs.push_back('{1, 32'h226, 32'h00008086, 3'd0, 1, 32'h228, 32'h00009086, 3'd0, 1});
        vecs.push_back('{0, 32'h0,   32'h0,        3'd0, 0, 32'h0,   32'h0,        3'd0, 1});
        vecs.push_back('{0, 32'h0,   32'h0,        3'd0, 0, 32'h0,   32'h0,        3'd0, 1});
        vecs.push_back('{1, 32'h22A, 32'h00009082, 3'd2, 1, 32'h22C, 32'h0000C006, 3'd4, 1});
        vecs.push_back('{1, 32'h22E, 32'h00004082, 3'd3, 1, 32'h230, 32'h0000C000, 3'd4, 1});
        vecs.push_back('{0, 32'h0,   32'h0,        3'd0, 0, 32'h0,   32'h0,        3'd0, 1});
        vecs.push_back('{0, 32'h0,   32'h0,        3'd0, 0, 32'h0,   32'h0,        3'd0, 1});
        vecs.push_back('{1, 32'h232, 32'h10500073, 3'd6, 1, 32'h236, 32'h0000100F, 3'd7, 1});
        vecs.push_back('{1, 32'h23A, 32'h00100073, 3'd6, 1, 32'h23E, 32'h00001063, 3'd1, 1});

        // Asynchronous reset with no clock edge involved
        #1 rst = 1'b1;
        #2;
        chk("reset_valid", 32'(trace_valid), 32'd0);
        chk("reset_pc", trace_pc, 32'd0);
        chk("reset_class", 32'(trace_class), 32'd0);
        chk("reset_drop", 32'(drop_count), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_stall", 32'(retire_stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].v0, vecs[i].pc0, vecs[i].i0, vecs[i].c0,
                 vecs[i].v1, vecs[i].pc1, vecs[i].i1, vecs[i].c1, vecs[i].rdy, 0);
        for (int i = 0; i < 10; i++) idle(1);
        chk("drained_drop", 32'(drop_count), 32'd0);

        // Overflow: five dual retires with the consumer stalled
        for (int i = 0; i < 5; i++) dual(32'h1000 + 32'(i * 8), 0);
        chk("ovf_drop2", 32'(drop_count), 32'd2);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_occ8", 32'(dut.r_occ), 32'd8);
        idle(1);
        dual(32'h1100, 0);
        chk("ovf_lane0_only_drop3", 32'(drop_count), 32'd3);

        // Full FIFO: pop and lane 0 write in the same cycle, no credit
        step(1, 32'h1200, 32'h00002003, 3'd3, 0, 32'd0, 32'd0, 3'd0, 1, 0);
        chk("full_occ7", 32'(dut.r_occ), 32'd7);
        chk("full_drop4", 32'(drop_count), 32'd4);

        // Flush with a dual retire in the same cycle
        idle(1);
        idle(1);
        step(1, 32'h1300, 32'h00A00093, 3'd0, 1, 32'h1304, 32'h0000006F, 3'd2, 0, 1);
        chk("flush_valid0", 32'(trace_valid), 32'd0);
        chk("flush_drop_kept", 32'(drop_count), 32'd4);
        chk("flush_ovf_kept", 32'(overflow), 32'd1);
        step(1, 32'h3000, 32'h00000063, 3'd1, 0, 32'd0, 32'd0, 3'd0, 0, 0);
        chk("post_flush_valid", 32'(trace_valid), 32'd1);
        chk("post_flush_pc", trace_pc, 32'h3000);
        for (int i = 0; i < 3; i++) idle(1);

`ifdef TRACE_BACKPRESSURE_EN
        // Core honours retire_stall: occupancy parks at 7 with no new drops
        for (int i = 0; i < 12; i++)
            step(!retire_stall, 32'h4000 + 32'(i * 4), 32'h00A00093, 3'd0,
                 0, 32'd0, 32'd0, 3'd0, 0, 0);
        chk("bp_stall_high", 32'(retire_stall), 32'd1);
        chk("bp_occ7", 32'(dut.r_occ), 32'd7);
        chk("bp_no_drop", 32'(drop_count), 32'd4);
        for (int i = 0; i < 9; i++) idle(1);
`endif

        // Reset mid-burst
        dual(32'h5000, 0);
        dual(32'h5008, 0);
        check_outputs();
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(trace_valid), 32'd0);
        chk("midrst_pc", trace_pc, 32'd0);
        chk("midrst_insn", trace_insn, 32'd0);
        chk("midrst_comp", 32'(trace_compressed), 32'd0);
        chk("midrst_drop", 32'(drop_count), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_stall", 32'(retire_stall), 32'd0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_drop = 0;
        m_ovf = 1'b0;
        m_stall = 1'b0;
        step(1, 32'h6000, 32'h00004108, 3'd3, 1, 32'h6002, 32'h00009002, 3'd6, 1, 0);
        for (int i = 0; i < 4; i++) idle(1);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
